// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source half of a two-phase request/acknowledge CDC.
// A registered word is held stable while the request toggle crosses over.
module cdc_handshake_tx #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [WIDTH-1:0] tx_data,
   output logic             tx_req,
   input  logic             rx_ack,
   output logic             busy,
   output logic             timeout,
   output logic             protocol_err
);

   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam int LIM_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CW-1:0] LIMIT = CW'(LIM_I);
   localparam bit TO_EN = (TIMEOUT != 0);

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } state_t;

   state_t state_q;
   state_t state_d;

   (* ASYNC_REG = "TRUE" *)
   logic [SYNC_STAGES-1:0] ack_sync;

   logic          ack_s;
   logic          accept;
   logic          ack_ok;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;

   assign ack_s   = ack_sync[SYNC_STAGES-1];
   assign s_ready = (state_q == ST_IDLE);
   assign busy    = (state_q == ST_WAIT);
   assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      ack_ok  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (s_valid) begin
               accept  = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (ack_s == tx_req) begin
               ack_ok  = 1'b1;
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Data and request change on the same edge; the far side's
   // synchroniser delay lets tx_data settle before it is used.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_sync     <= '0;
         tx_data      <= '0;
         tx_req       <= 1'b0;
         cnt          <= '0;
         timeout      <= 1'b0;
         protocol_err <= 1'b0;
      end else begin
         ack_sync <= {ack_sync[SYNC_STAGES-2:0], rx_ack};
         if (accept) begin
            tx_data <= s_data;
            tx_req  <= ~tx_req;
            cnt     <= '0;
         end else if (busy && !ack_ok) begin
            cnt <= cnt_inc;
            if (TO_EN && cnt_inc >= LIMIT) begin
               timeout <= 1'b1;
            end
         end
         if (s_ready && (ack_s != tx_req)) begin
            protocol_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx: randomized bench with a far-side echo model
// and a scoreboard of words seen on each request toggle.
module tb_cdc_handshake_tx;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] s_data = '0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [W-1:0] tx_data;
   logic         tx_req;
   logic         rx_ack = 1'b0;
   logic         busy;
   logic         timeout;
   logic         protocol_err;

   int vecs = 0;
   int errs = 0;

   logic req_exp = 1'b0;
   bit   echo_en = 1'b0;
   int   echo_dly = 2;
   logic echo_v;
   bit   mon_en = 1'b0;
   logic last_req = 1'b0;
   logic [W-1:0] got[$];

   cdc_handshake_tx #(
      .WIDTH(W),
      .SYNC_STAGES(2),
      .TIMEOUT(16)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .s_data(s_data),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .tx_data(tx_data),
      .tx_req(tx_req),
      .rx_ack(rx_ack),
      .busy(busy),
      .timeout(timeout),
      .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   // Far side: echo each request toggle back after echo_dly cycles.
   always @(tx_req) begin
      if (echo_en) begin
         echo_v = tx_req;
         repeat (echo_dly) @(posedge clk);
         #2;
         if (echo_en) rx_ack = echo_v;
      end
   end

   always @(posedge clk) begin
      #1;
      if (mon_en && tx_req !== last_req) begin
         got.push_back(tx_data);
         last_req = tx_req;
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      s_valid = 1'b0;
      s_data = '0;
      rx_ack = 1'b0;
      echo_en = 1'b0;
      req_exp = 1'b0;
      repeat (2) @(negedge clk);
      vecs++;
      if ({s_ready, busy, tx_req, timeout, protocol_err, tx_data}
          !== {5'b10000, 16'h0}) begin
         errs++;
         $display("FAIL reset: got rdy=%b bsy=%b req=%b to=%b pe=%b d=%h",
                  s_ready, busy, tx_req, timeout, protocol_err, tx_data);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      int n;
      s_data = 16'hA5C3;
      s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      req_exp = ~req_exp;
      vecs++;
      if ({tx_req, tx_data, s_ready, busy} !== {1'b1, 16'hA5C3, 2'b01}) begin
         errs++;
         $display("FAIL single_accept: req=%b d=%h rdy=%b bsy=%b want 1 a5c3 0 1",
                  tx_req, tx_data, s_ready, busy);
      end
      repeat (5) @(posedge clk);
      #2 rx_ack = req_exp;
      n = 0;
      while (!s_ready && n < 20) begin
         @(posedge clk);
         #1 n++;
      end
      vecs++;
      if (n != 3) begin
         errs++;
         $display("FAIL single_ack_latency: got %0d cycles want 3", n);
      end
      @(negedge clk);
   endtask

   task automatic test_hold();
      int n;
      s_data = 16'hA5C3;
      s_valid = 1'b1;
      @(negedge clk);
      req_exp = ~req_exp;
      s_data = 16'h1234;
      for (int k = 0; k < 4; k++) begin
         vecs++;
         if ({busy, tx_req, tx_data} !== {1'b1, req_exp, 16'hA5C3}) begin
            errs++;
            $display("FAIL hold_wait%0d: bsy=%b req=%b d=%h want 1 %b a5c3",
                     k, busy, tx_req, tx_data, req_exp);
         end
         @(negedge clk);
      end
      rx_ack = req_exp;
      repeat (2) @(negedge clk);
      vecs++;
      if (s_ready !== 1'b0) begin
         errs++;
         $display("FAIL hold_early_ready: got %b want 0", s_ready);
      end
      @(negedge clk);
      vecs++;
      if ({s_ready, tx_data} !== {1'b1, 16'hA5C3}) begin
         errs++;
         $display("FAIL hold_ready: rdy=%b d=%h want 1 a5c3", s_ready, tx_data);
      end
      @(negedge clk);
      s_valid = 1'b0;
      req_exp = ~req_exp;
      vecs++;
      if ({busy, tx_req, tx_data} !== {1'b1, req_exp, 16'h1234}) begin
         errs++;
         $display("FAIL hold_next: bsy=%b req=%b d=%h want 1 %b 1234",
                  busy, tx_req, tx_data, req_exp);
      end
      rx_ack = req_exp;
      n = 0;
      while (!s_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_streaming();
      int idx;
      int cyc;
      bit acc;
      logic [W-1:0] g;
      idx = 0;
      cyc = 0;
      got.delete();
      last_req = tx_req;
      mon_en = 1'b1;
      echo_dly = 2;
      echo_en = 1'b1;
      s_data = '0;
      s_valid = 1'b1;
      while (idx < 8 && cyc < 300) begin
         acc = s_valid && s_ready;
         @(negedge clk);
         cyc++;
         if (acc) begin
            idx++;
            req_exp = ~req_exp;
            s_data = W'(idx);
            if (idx == 8) s_valid = 1'b0;
         end
      end
      s_valid = 1'b0;
      cyc = 0;
      while (!s_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      echo_en = 1'b0;
      mon_en = 1'b0;
      vecs++;
      if (idx != 8 || !s_ready) begin
         errs++;
         $display("FAIL stream_stall: accepted %0d want 8, rdy=%b", idx, s_ready);
      end
      vecs++;
      if (got.size() != 8) begin
         errs++;
         $display("FAIL stream_count: got %0d toggles want 8", got.size());
      end
      for (int i = 0; i < 8; i++) begin
         g = (i < got.size()) ? got[i] : 'x;
         vecs++;
         if (g !== W'(i)) begin
            errs++;
            $display("FAIL stream_word%0d: got %h want %h", i, g, W'(i));
         end
      end
      vecs++;
      if ({tx_req, timeout, protocol_err} !== {req_exp, 2'b00}) begin
         errs++;
         $display("FAIL stream_flags: req=%b to=%b pe=%b want %b 0 0",
                  tx_req, timeout, protocol_err, req_exp);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] exp_q[$];
      logic [W-1:0] g;
      int n;
      int cyc;
      bit acc;
      n = 0;
      cyc = 0;
      got.delete();
      last_req = tx_req;
      mon_en = 1'b1;
      echo_en = 1'b1;
      s_valid = 1'b0;
      while (n < 24 && cyc < 2000) begin
         if (!s_valid && $urandom_range(0, 1) == 1) begin
            s_valid = 1'b1;
            s_data = W'($urandom);
         end
         echo_dly = $urandom_range(1, 6);
         acc = s_valid && s_ready;
         if (acc) exp_q.push_back(s_data);
         @(negedge clk);
         cyc++;
         if (acc) begin
            n++;
            req_exp = ~req_exp;
            s_valid = 1'b0;
            vecs++;
            if ({s_ready, tx_req, tx_data} !== {1'b0, req_exp, exp_q[$]}) begin
               errs++;
               $display("FAIL rand_accept%0d: rdy=%b req=%b d=%h want 0 %b %h",
                        n, s_ready, tx_req, tx_data, req_exp, exp_q[$]);
            end
         end
      end
      cyc = 0;
      while (!s_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      echo_en = 1'b0;
      mon_en = 1'b0;
      vecs++;
      if (got.size() != exp_q.size() || n != 24) begin
         errs++;
         $display("FAIL rand_count: got %0d toggles, %0d accepts want 24",
                  got.size(), n);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (i < got.size()) ? got[i] : 'x;
         vecs++;
         if (g !== exp_q[i]) begin
            errs++;
            $display("FAIL rand_word%0d: got %h want %h", i, g, exp_q[i]);
         end
      end
   endtask

   task automatic test_timeout();
      logic to_exp;
      s_data = W'($urandom);
      s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      req_exp = ~req_exp;
      for (int k = 1; k <= 20; k++) begin
         to_exp = (k >= 16);
         vecs++;
         if ({timeout, busy} !== {to_exp, 1'b1}) begin
            errs++;
            $display("FAIL timeout_cyc%0d: to=%b bsy=%b want %b 1",
                     k, timeout, busy, to_exp);
         end
         @(negedge clk);
      end
      rx_ack = req_exp;
      repeat (3) @(negedge clk);
      vecs++;
      if ({s_ready, busy, timeout} !== 3'b101) begin
         errs++;
         $display("FAIL timeout_recover: rdy=%b bsy=%b to=%b want 1 0 1",
                  s_ready, busy, timeout);
      end
   endtask

   task automatic test_protocol();
      rx_ack = ~rx_ack;
      repeat (2) @(negedge clk);
      vecs++;
      if (protocol_err !== 1'b0) begin
         errs++;
         $display("FAIL proto_early: got %b want 0", protocol_err);
      end
      @(negedge clk);
      vecs++;
      if ({protocol_err, s_ready, tx_req} !== {2'b11, req_exp}) begin
         errs++;
         $display("FAIL proto_err: pe=%b rdy=%b req=%b want 1 1 %b",
                  protocol_err, s_ready, tx_req, req_exp);
      end
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0;
      rx_ack = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      req_exp = 1'b0;
      s_data = W'($urandom) | 16'h8000;
      s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      vecs++;
      if ({busy, tx_req, timeout, protocol_err} !== 4'b1100) begin
         errs++;
         $display("FAIL mid_pre: bsy=%b req=%b to=%b pe=%b want 1 1 0 0",
                  busy, tx_req, timeout, protocol_err);
      end
      #2 rst_n = 1'b0;
      #1;
      vecs++;
      if ({s_ready, busy, tx_req, timeout, protocol_err, tx_data}
          !== {5'b10000, 16'h0}) begin
         errs++;
         $display("FAIL mid_reset: rdy=%b bsy=%b req=%b to=%b pe=%b d=%h",
                  s_ready, busy, tx_req, timeout, protocol_err, tx_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_hold();
      test_streaming();
      test_random();
      test_timeout();
      test_protocol();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/cdc_handshake_tx.md
Name: cdc_handshake_tx

Overview:
Source-side half of a two-phase (toggle) request/acknowledge clock-domain crossing for multi-bit words, e.g. audio samples or control words leaving the local domain. It accepts a word on a local valid/ready interface and registers it onto a bus held stable for the far domain. It then toggles a request line and waits for the far-domain acknowledge toggle, which it brings into `clk` through its own synchroniser chain. Pairs with a far-side receiver that samples the request through a 2-FF synchroniser and echoes it back as the acknowledge.

Parameters:
- WIDTH, 16, width of the transferred data word.
- SYNC_STAGES, 2, flops in the acknowledge synchroniser chain; minimum 2.
- TIMEOUT, 1024, `clk` cycles to wait for acknowledge before flagging timeout; 0 disables the timeout.

Ports:
- clk  input  1  local clock.
- rst_n  input  1  asynchronous active-low reset.
- s_data  input  WIDTH  word to send.
- s_valid  input  1  s_data valid.
- s_ready  output  1  block can accept a word.
- tx_data  output  WIDTH  registered word to far domain; stable whenever tx_req may be sampled.
- tx_req  output  1  request toggle to far domain; registered output.
- rx_ack  input  1  acknowledge toggle from far domain; asynchronous to clk.
- busy  output  1  transfer in flight.
- timeout  output  1  sticky: acknowledge not seen within TIMEOUT cycles.
- protocol_err  output  1  sticky: acknowledge toggled while no transfer was pending.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-low, on `rst_n`.
- Reset values: tx_req=0, tx_data=0, all synchroniser flops=0, state=IDLE, timeout counter=0, timeout=0, protocol_err=0, busy=0, s_ready=1.
- Acknowledge synchroniser:
  - rx_ack passes through SYNC_STAGES flops, each marked ASYNC_REG="TRUE".
  - The last stage is ack_s. Only ack_s is used by the control logic.
- s_ready = (state==IDLE). This is purely a decode of the state register; there is no combinational path from s_valid.
- busy = (state==WAIT).
- State IDLE:
  - On s_valid && s_ready: tx_data <= s_data, tx_req <= ~tx_req, counter <= 0, next state WAIT.
  - tx_data and tx_req change on the same edge. The far side synchronises tx_req by at least 2 flops, so data settles before use.
  - If ack_s != tx_req while in IDLE: set protocol_err, stay in IDLE, no other effect.
- State WAIT:
  - tx_data and tx_req hold; s_data and s_valid are ignored.
  - When ack_s == tx_req: next state IDLE, so s_ready=1 on the following cycle.
  - Otherwise counter increments, saturating. When TIMEOUT != 0 and counter reaches TIMEOUT-1, set timeout and remain in WAIT. Waiting continues indefinitely; there is no retransmit.
- Latency:
  - Accept edge to tx_req toggle: 0 cycles (the toggle is registered on the accept edge).
  - Far-domain ack toggle to s_ready high: SYNC_STAGES+1 `clk` cycles.
  - Maximum throughput is one word per round trip.
- Back-to-back: a word presented on the first cycle s_ready returns is accepted that cycle. tx_req toggles again on that edge.
- Sticky flags clear only on reset.
- Reset mid-transfer: everything returns to reset values immediately, including tx_req=0. The far-side receiver must also be reset for the pair to resynchronise. If it is not, protocol_err is the documented symptom.
- Counter width is ceil(log2(TIMEOUT+1)), minimum 1.

Test Plan:
- Single transfer: reset, present s_data=16'hA5C3 with s_valid for one cycle. Required: tx_req 0->1 and tx_data=A5C3 on the same edge; s_ready=0 and busy=1. Model far side: echo tx_req to rx_ack 5 cycles later. Required: s_ready=1 exactly SYNC_STAGES+1=3 cycles after the rx_ack edge.
- Hold during WAIT: while busy, drive s_data=16'h1234 with s_valid=1. Required: tx_data stays A5C3 and tx_req does not toggle. After the ack, 1234 is accepted on the first s_ready cycle and tx_req toggles back to 0.
- Streaming: 8 words 0..7, s_valid held high, far side echoing after 2 cycles. Required: tx_data sequence 0..7 with no loss or duplication, tx_req alternating, no flags set.
- Timeout: TIMEOUT=16, accept a word, never toggle rx_ack. Required: timeout=1 on the 16th WAIT cycle, state stays WAIT. Toggling rx_ack afterwards returns to IDLE with timeout still 1.
- Protocol error: in IDLE, toggle rx_ack. Required: protocol_err=1 after SYNC_STAGES+1 cycles, s_ready stays 1, tx_req unchanged.
- Reset mid-transfer: assert rst_n=0 while busy, asynchronously mid-cycle. Required: tx_req, tx_data, busy and flags go to 0, and s_ready goes to 1, without waiting for a clk edge.
